escape_iterator: RTL and testbench
==================================

ESCAPE_ITERATOR -- requirements
Module: escape_iterator

Interface
REQ-001 SHALL have parameter FRAC, default 28: fractional bits of every fixed-point operand; total width W = FRAC+4 (sign + 3 integer bits).
REQ-002 SHALL have parameter ITER_W, default 16: width of iteration count and limit.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = Mandelbrot, 1 = Julia.
REQ-007 SHALL have ports x, y  input  12 each  unsigned pixel coordinates.
REQ-008 SHALL have ports re_start, im_start  input  W each  signed fixed-point origin.
REQ-009 SHALL have ports re_scale, im_scale  input  W each  unsigned fixed-point step per pixel.
REQ-010 SHALL have ports jul_re, jul_im  input  W each  signed Julia constant.
REQ-011 SHALL have port max_iter  input  ITER_W  iteration limit.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port iteration  output  ITER_W  result count, held until next accepted start.
REQ-015 SHALL have port escaped  output  1  1 = |z|^2 exceeded 4; 0 = limit reached.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ITER -> DONE -> IDLE.
REQ-017 SHALL, in IDLE with start=1, register all inputs, clear iteration and escaped, and go to SETUP; start in any other state SHALL be ignored.
REQ-018 SHALL, in SETUP, form p = (re_start + x*re_scale, im_start + y*im_scale), truncated to W; mode 0: z=0, c=p; mode 1: z=p, c=(jul_re, jul_im).
REQ-019 SHALL, each ITER cycle, in priority order: if iteration == max_iter -> DONE, escaped=0; else if re^2+im^2 > 4 -> DONE, escaped=1; else z <= (re^2 - im^2 + c_re, 2*re*im + c_im) and iteration += 1.
REQ-020 SHALL evaluate the escape compare on full 2W-bit products without truncation or wrap; z update SHALL saturate to W-bit signed range.
REQ-021 SHALL assert done in DONE for exactly one cycle, then return to IDLE; a start in the DONE cycle is ignored.
REQ-022 SHALL have latency: for result n, done high in the cycle after edge e+n+2, where e is the edge sampling start.
REQ-023 SHALL treat |z|^2 == 4 exactly as not escaped.
REQ-024 SHALL, with max_iter=0, finish with iteration=0, escaped=0, regardless of z.

Reset
REQ-025 SHALL, on RST=1 at any edge including mid-computation, enter IDLE with busy=0, done=0, iteration=0, escaped=0, and internal z, c cleared.
REQ-026 SHALL give RST priority over start on the same edge.

Structure
REQ-027 SHALL take FRAC default, state enum, and the fixed-point constant FOUR from shared package mandel_pkg.
REQ-028 SHALL instantiate sub-module fixed_mul_full (signed W x W -> 2W product) three times: re^2, im^2, re*im; pixel scaling SHALL use the same sub-module.

Verification
REQ-029 Mandelbrot, scales 0, re_start=1.0, im_start=0, max_iter=100 -> iteration=3, escaped=1, done after e+5.
REQ-030 Mandelbrot, origin 0, scales 0, max_iter=100 -> iteration=100, escaped=0.
REQ-031 Julia, jul=(0,0), re_start=3.0, scales 0, max_iter=50 -> iteration=0, escaped=1; re_start=0.5 -> iteration=50, escaped=0.
REQ-032 max_iter=0, any point -> iteration=0, escaped=0, done after e+2.
REQ-033 RST pulsed 10 cycles into a 100-iteration run -> next cycle busy=0, iteration=0, no done pulse; fresh start then completes normally.
REQ-034 start held high throughout a run -> exactly one done per accepted request; starts during SETUP/ITER/DONE ignored.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared definitions for the escape-time iterator: default precision,
// FSM encoding and the escape radius squared.
package mandel_pkg;

  localparam int FRAC_DEFAULT = 28;

  // Integer value of |z|^2 escape bound; each user scales it to its own format.
  localparam int FOUR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fixed_mul_full.sv
// Full-precision signed multiplier, W x W -> 2W; combinational, no flow control.
module fixed_mul_full #(
  parameter int W = 32
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic signed [2*W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/escape_iterator.sv
// Mandelbrot/Julia escape-time iterator; one z update per ITER cycle.
// Latency n+2 cycles from accepted start to done; start ignored while busy.
module escape_iterator
  import mandel_pkg::*;
#(
  parameter int  FRAC   = FRAC_DEFAULT,
  parameter int  ITER_W = 16,
  localparam int W      = FRAC + 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                mode,
  input  logic [11:0]         x,
  input  logic [11:0]         y,
  input  logic signed [W-1:0] re_start,
  input  logic signed [W-1:0] im_start,
  input  logic [W-1:0]        re_scale,
  input  logic [W-1:0]        im_scale,
  input  logic signed [W-1:0] jul_re,
  input  logic signed [W-1:0] jul_im,
  input  logic [ITER_W-1:0]   max_iter,
  output logic                busy,
  output logic                done,
  output logic [ITER_W-1:0]   iteration,
  output logic                escaped
);

  localparam int P = 2 * W;
  localparam int S = W + 1;  // pixel multiply needs a spare bit for unsigned operands
  localparam logic signed [P+1:0] FOUR_Q = (P+2)'(FOUR) <<< (2 * FRAC);
  localparam logic signed [P+1:0] MAX_L  = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [P+1:0] MIN_L  = {{(W+3){1'b1}}, {(W-1){1'b0}}};

  state_t state_q, state_d;

  logic                mode_q;
  logic [11:0]         x_q, y_q;
  logic signed [W-1:0] re_start_q, im_start_q, jul_re_q, jul_im_q;
  logic [W-1:0]        re_scale_q, im_scale_q;
  logic [ITER_W-1:0]   max_iter_q, iter_q;
  logic                esc_q;
  logic signed [W-1:0] z_re_q, z_im_q, c_re_q, c_im_q;
  logic signed [W-1:0] z_re_d, z_im_d;

  // Pixel to complex-plane mapping.
  logic signed [S-1:0]   x_ext, y_ext, rsc_ext, isc_ext;
  logic signed [2*S-1:0] re_off, im_off;
  logic signed [W-1:0]   p_re, p_im;
  logic                  unused_off_hi;

  assign x_ext   = $signed({{(S-12){1'b0}}, x_q});
  assign y_ext   = $signed({{(S-12){1'b0}}, y_q});
  assign rsc_ext = $signed({1'b0, re_scale_q});
  assign isc_ext = $signed({1'b0, im_scale_q});

  fixed_mul_full #(.W(S)) u_mul_px (.a_i(x_ext), .b_i(rsc_ext), .p_o(re_off));
  fixed_mul_full #(.W(S)) u_mul_py (.a_i(y_ext), .b_i(isc_ext), .p_o(im_off));

  assign p_re          = re_start_q + re_off[W-1:0];
  assign p_im          = im_start_q + im_off[W-1:0];
  assign unused_off_hi = ^{re_off[2*S-1:W], im_off[2*S-1:W]};

  // Iteration datapath.
  logic signed [P-1:0] re2, im2, reim;
  logic signed [P+1:0] mag2, re_wide, im_wide;
  logic                escape, at_limit;

  fixed_mul_full #(.W(W)) u_mul_re2  (.a_i(z_re_q), .b_i(z_re_q), .p_o(re2));
  fixed_mul_full #(.W(W)) u_mul_im2  (.a_i(z_im_q), .b_i(z_im_q), .p_o(im2));
  fixed_mul_full #(.W(W)) u_mul_reim (.a_i(z_re_q), .b_i(z_im_q), .p_o(reim));

  assign mag2     = (P+2)'(re2) + (P+2)'(im2);
  assign escape   = mag2 > FOUR_Q;
  assign at_limit = iter_q == max_iter_q;
  assign re_wide  = (((P+2)'(re2) - (P+2)'(im2)) >>> FRAC) + (P+2)'(c_re_q);
  assign im_wide  = (((P+2)'(reim) <<< 1) >>> FRAC) + (P+2)'(c_im_q);

  function automatic logic signed [W-1:0] sat(input logic signed [P+1:0] v);
    if (v > MAX_L)      return {1'b0, {(W-1){1'b1}}};
    else if (v < MIN_L) return {1'b1, {(W-1){1'b0}}};
    else                return v[W-1:0];
  endfunction

  assign z_re_d = sat(re_wide);
  assign z_im_d = sat(im_wide);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = ITER;
      ITER:    if (at_limit || escape) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      re_start_q <= '0;
      im_start_q <= '0;
      re_scale_q <= '0;
      im_scale_q <= '0;
      jul_re_q   <= '0;
      jul_im_q   <= '0;
      max_iter_q <= '0;
      iter_q     <= '0;
      esc_q      <= 1'b0;
      z_re_q     <= '0;
      z_im_q     <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mode_q     <= mode;
          x_q        <= x;
          y_q        <= y;
          re_start_q <= re_start;
          im_start_q <= im_start;
          re_scale_q <= re_scale;
          im_scale_q <= im_scale;
          jul_re_q   <= jul_re;
          jul_im_q   <= jul_im;
          max_iter_q <= max_iter;
          iter_q     <= '0;
          esc_q      <= 1'b0;
        end
        SETUP: begin
          if (mode_q) begin
            z_re_q <= p_re;
            z_im_q <= p_im;
            c_re_q <= jul_re_q;
            c_im_q <= jul_im_q;
          end else begin
            z_re_q <= '0;
            z_im_q <= '0;
            c_re_q <= p_re;
            c_im_q <= p_im;
          end
        end
        ITER: begin
          if (at_limit) begin
            esc_q <= 1'b0;
          end else if (escape) begin
            esc_q <= 1'b1;
          end else begin
            z_re_q <= z_re_d;
            z_im_q <= z_im_d;
            iter_q <= iter_q + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign iteration = iter_q;
  assign escaped   = esc_q;

endmodule

// File: tb/tb_escape_iterator.sv
// Self-checking bench for escape_iterator: directed vectors, random points
// against an arithmetic reference, reset and start-handling scenarios.
module tb_escape_iterator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b1;
  logic        mode = 1'b0;
  logic [11:0] x = '0, y = '0;
  logic [31:0] re_start = '0, im_start = '0, re_scale = '0, im_scale = '0;
  logic [31:0] jul_re = '0, jul_im = '0;
  logic [15:0] max_iter = '0;
  logic        busy, done, escaped;
  logic [15:0] iteration;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  escape_iterator dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .x(x), .y(y),
    .re_start(re_start), .im_start(im_start), .re_scale(re_scale), .im_scale(im_scale),
    .jul_re(jul_re), .jul_im(jul_im), .max_iter(max_iter),
    .busy(busy), .done(done), .iteration(iteration), .escaped(escaped)
  );

  // Reference: complex iteration in wide signed integers, FRAC = 28.
  function automatic void model(input logic md, input logic [11:0] px, input logic [11:0] py,
                                input logic [31:0] rs, input logic [31:0] ims,
                                input logic [31:0] rsc, input logic [31:0] isc,
                                input logic [31:0] jr, input logic [31:0] ji,
                                input logic [15:0] mi, output int n, output logic esc);
    logic signed [127:0] zr, zi, cr, ci, pr, pim, tr, ti;
    logic signed [127:0] maxv, minv, lim;
    logic signed [31:0]  wr, wi;
    maxv = 128'sd2147483647;
    minv = -128'sd2147483648;
    lim  = 128'sd4 <<< 56;
    wr   = rs + 32'(px) * rsc;
    wi   = ims + 32'(py) * isc;
    pr   = wr;
    pim  = wi;
    if (md) begin
      zr = pr; zi = pim; cr = $signed(jr); ci = $signed(ji);
    end else begin
      zr = 0; zi = 0; cr = pr; ci = pim;
    end
    n = 0;
    esc = 1'b0;
    while (1) begin
      if (n == int'(mi)) break;
      if (zr * zr + zi * zi > lim) begin
        esc = 1'b1;
        break;
      end
      tr = ((zr * zr - zi * zi) >>> 28) + cr;
      ti = ((2 * zr * zi) >>> 28) + ci;
      zr = (tr > maxv) ? maxv : (tr < minv) ? minv : tr;
      zi = (ti > maxv) ? maxv : (ti < minv) ? minv : ti;
      n++;
    end
  endfunction

  task automatic do_run(input logic md, input logic [11:0] px, input logic [11:0] py,
                        input logic [31:0] rs, input logic [31:0] ims,
                        input logic [31:0] rsc, input logic [31:0] isc,
                        input logic [31:0] jr, input logic [31:0] ji, input logic [15:0] mi,
                        output logic [15:0] it_o, output logic esc_o, output int lat_o,
                        output logic busy_ok, output logic pulse_ok);
    @(negedge CLK);
    mode = md; x = px; y = py; re_start = rs; im_start = ims;
    re_scale = rsc; im_scale = isc; jul_re = jr; jul_im = ji; max_iter = mi;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    busy_ok = (busy === 1'b1);
    lat_o   = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge CLK);
      #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat_o = k;
        break;
      end
    end
    it_o  = iteration;
    esc_o = escaped;
    @(posedge CLK);
    #1;
    pulse_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (iteration !== 16'd0) $display("FAIL reset_iter: got %0d want 0", iteration); else n_pass++;
    n_checks++; if (escaped !== 1'b0) $display("FAIL reset_esc: got %b want 0", escaped); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    start = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_after_reset: busy %b want 0", busy); else n_pass++;
  endtask

  typedef struct {
    logic        md;
    logic [31:0] rs;
    logic [15:0] mi;
    int          it;
    logic        esc;
  } dvec_t;

  task automatic test_directed();
    dvec_t       tbl[7];
    logic [15:0] it_g;
    logic        esc_g, b_ok, p_ok;
    int          lat;
    tbl[0] = '{1'b0, 32'h1000_0000, 16'd100, 3,   1'b1};  // c = 1.0
    tbl[1] = '{1'b0, 32'h0000_0000, 16'd100, 100, 1'b0};  // c = 0
    tbl[2] = '{1'b1, 32'h3000_0000, 16'd50,  0,   1'b1};  // z = 3.0
    tbl[3] = '{1'b1, 32'h0800_0000, 16'd50,  50,  1'b0};  // z = 0.5
    tbl[4] = '{1'b1, 32'h3000_0000, 16'd0,   0,   1'b0};  // limit 0 beats escape
    tbl[5] = '{1'b1, 32'h2000_0000, 16'd1,   1,   1'b0};  // |z|^2 == 4 exactly
    tbl[6] = '{1'b0, 32'he000_0000, 16'd20,  20,  1'b0};  // c = -2, orbit on radius 2
    for (int i = 0; i < 7; i++) begin
      do_run(tbl[i].md, 12'd0, 12'd0, tbl[i].rs, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
             tbl[i].mi, it_g, esc_g, lat, b_ok, p_ok);
      n_checks++;
      if (it_g !== tbl[i].it[15:0]) $display("FAIL dir%0d_iter: got %0d want %0d", i, it_g, tbl[i].it);
      else n_pass++;
      n_checks++;
      if (esc_g !== tbl[i].esc) $display("FAIL dir%0d_esc: got %b want %b", i, esc_g, tbl[i].esc);
      else n_pass++;
      n_checks++;
      if (lat != tbl[i].it + 2) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].it + 2);
      else n_pass++;
      n_checks++;
      if (!(b_ok && p_ok)) $display("FAIL dir%0d_busy_pulse: busy_ok %b pulse_ok %b want 1 1", i, b_ok, p_ok);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic              md;
    logic [11:0]       px, py;
    logic signed [31:0] r;
    logic [31:0]       rs, ims, rsc, isc, jr, ji;
    logic [15:0]       mi, it_g;
    logic              esc_g, esc_m, b_ok, p_ok;
    int                n_m, lat;
    for (int i = 0; i < 25; i++) begin
      md = 1'($urandom_range(0, 1));
      px = 12'($urandom_range(0, 4095));
      py = 12'($urandom_range(0, 4095));
      r = $urandom; rs  = r >>> 2;
      r = $urandom; ims = r >>> 2;
      r = $urandom; jr  = r >>> 3;
      r = $urandom; ji  = r >>> 3;
      case ($urandom_range(0, 3))
        0:       begin rsc = 32'd0; isc = 32'd0; end
        3:       begin rsc = $urandom; isc = $urandom; end
        default: begin rsc = $urandom_range(0, 1 << 20); isc = $urandom_range(0, 1 << 20); end
      endcase
      mi = 16'($urandom_range(0, 60));
      model(md, px, py, rs, ims, rsc, isc, jr, ji, mi, n_m, esc_m);
      do_run(md, px, py, rs, ims, rsc, isc, jr, ji, mi, it_g, esc_g, lat, b_ok, p_ok);
      n_checks++;
      if (it_g !== n_m[15:0]) $display("FAIL rnd%0d_iter: got %0d want %0d", i, it_g, n_m);
      else n_pass++;
      n_checks++;
      if (esc_g !== esc_m) $display("FAIL rnd%0d_esc: got %b want %b", i, esc_g, esc_m);
      else n_pass++;
      n_checks++;
      if (lat != n_m + 2) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, n_m + 2);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    int          dones;
    logic [15:0] it_g;
    logic        esc_g, b_ok, p_ok;
    int          lat;
    @(negedge CLK);
    mode = 1'b0; x = '0; y = '0; re_start = '0; im_start = '0; re_scale = '0; im_scale = '0;
    max_iter = 16'd100; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (iteration !== 16'd0) $display("FAIL midrst_iter: got %0d want 0", iteration); else n_pass++;
    n_checks++; if (escaped !== 1'b0) $display("FAIL midrst_esc: got %b want 0", escaped); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", dones); else n_pass++;
    do_run(1'b0, 12'd0, 12'd0, 32'h1000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd100,
           it_g, esc_g, lat, b_ok, p_ok);
    n_checks++; if (it_g !== 16'd3) $display("FAIL midrst_rerun_iter: got %0d want 3", it_g); else n_pass++;
    n_checks++; if (esc_g !== 1'b1) $display("FAIL midrst_rerun_esc: got %b want 1", esc_g); else n_pass++;
    n_checks++; if (lat != 5) $display("FAIL midrst_rerun_latency: got %0d want 5", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int          dones, t1, t2, extra;
    logic [15:0] it1, it2;
    @(negedge CLK);
    mode = 1'b0; x = '0; y = '0; re_start = '0; im_start = '0; re_scale = '0; im_scale = '0;
    jul_re = '0; jul_im = '0; max_iter = 16'd5; start = 1'b1;
    @(posedge CLK);
    #1;
    max_iter = 16'd0;  // must not affect the request already accepted
    dones = 0; t1 = -1; t2 = -1; it1 = '0; it2 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          t1 = c; it1 = iteration; max_iter = 16'd5;
        end else begin
          t2 = c; it2 = iteration; start = 1'b0;
          break;
        end
      end
    end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1) extra++;
    end
    n_checks++; if (t1 != 7) $display("FAIL held_first_done: got cycle %0d want 7", t1); else n_pass++;
    n_checks++; if (it1 !== 16'd5) $display("FAIL held_first_iter: got %0d want 5", it1); else n_pass++;
    n_checks++; if (t2 != 16) $display("FAIL held_second_done: got cycle %0d want 16", t2); else n_pass++;
    n_checks++; if (it2 !== 16'd5) $display("FAIL held_second_iter: got %0d want 5", it2); else n_pass++;
    n_checks++; if (extra != 0) $display("FAIL held_extra_done: got %0d pulses want 0", extra); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL held_final_busy: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
